// File: rtl/mult_div_unit_if.sv
// Bus bundle for mult_div_unit: operation request, HI/LO move-to writes and result/status outputs.
`timescale 1ns/1ps
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, wr_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, wr_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO unit: shift-add multiply and restoring divide, one bit per cycle,
// on magnitudes with sign correction applied when the result is written.
`timescale 1ns/1ps
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  mult_div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
  logic [2*WIDTH-1:0] prod;
  logic               sgn_in;

  always_comb begin
    sgn_in   = ~bus.op[0];
    mag_a    = (sgn_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b    = (sgn_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, mag_q};
    prod     = ((op_q == OP_MULT) && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -acc_q : acc_q;
    quo      = ((op_q == OP_DIV) && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -acc_q[WIDTH-1:0]
                                                                   : acc_q[WIDTH-1:0];
    rem      = ((op_q == OP_DIV) && a_q[WIDTH-1]) ? -acc_q[2*WIDTH-1:WIDTH]
                                                  : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = op_e'(bus.op);
          a_d     = bus.a;
          b_d     = bus.b;
          mag_d   = bus.op[1] ? mag_b : mag_a;
          acc_d   = {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          if (bus.wr_hi) hi_d = bus.wr_data;
          if (bus.wr_lo) lo_d = bus.wr_data;
        end
      end
      RUN: begin
        if (op_q[1]) begin
          acc_d = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
      end
      FINISH: begin
        if (!op_q[1]) begin
          {hi_d, lo_d} = prod;
        end else if (b_q == '0) begin
          lo_d = '1;
          hi_d = a_q;
          dz_d = 1'b1;
        end else begin
          lo_d = quo;
          hi_d = rem;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      mag_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): directed table, corner sequences and
// random operations compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mult_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus ();
  mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_hi, exp_lo;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'd0: begin p = 64'(sa * sb); {hi, lo} = p; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; {hi, lo} = p; end
      default: begin
        if (b == '0) begin
          lo = '1; hi = a; dz = 1'b1;
        end else if (op == 2'd2) begin
          q = sa / sb; r = sa % sb;
          lo = q[W-1:0]; hi = r[W-1:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  // Called one step after the start edge; returns one step into the done cycle.
  task automatic finish_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input string nm);
    logic [W-1:0] mh, ml;
    logic md;
    int lat = 0;
    bit seen = 0;
    model(op, a, b, mh, ml, md);
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) seen = 1;
      else begin
        chk({nm, "_busy"}, 64'(bus.busy), 64'd1);
        chk({nm, "_dz_early"}, 64'(bus.div_by_zero), 64'd0);
        chk({nm, "_hold"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
      end
    end
    chk({nm, "_done_seen"}, 64'(seen), 64'd1);
    chk({nm, "_latency"}, 64'(lat), 64'd33);
    chk({nm, "_busy_in_done"}, 64'(bus.busy), 64'd0);
    chk({nm, "_hi"}, 64'(bus.hi), 64'(mh));
    chk({nm, "_lo"}, 64'(bus.lo), 64'(ml));
    chk({nm, "_dz"}, 64'(bus.div_by_zero), 64'(md));
    exp_hi = mh;
    exp_lo = ml;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string nm);
    issue(op, a, b);
    finish_op(op, a, b, nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    logic [1:0] rop;
    logic [W-1:0] ra, rb;

    vecs[0] = '{op: 2'd0, a: 32'hFFFFFFFD, b: 32'd7,        hi: 32'hFFFFFFFF, lo: 32'hFFFFFFEB, dz: 1'b0};
    vecs[1] = '{op: 2'd1, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, hi: 32'hFFFFFFFE, lo: 32'h00000001, dz: 1'b0};
    vecs[2] = '{op: 2'd0, a: 32'h00000006, b: 32'hFFFFFFFC, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFE8, dz: 1'b0};
    vecs[3] = '{op: 2'd2, a: 32'hFFFFFFF9, b: 32'd2,        hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD, dz: 1'b0};
    vecs[4] = '{op: 2'd2, a: 32'h80000000, b: 32'hFFFFFFFF, hi: 32'h00000000, lo: 32'h80000000, dz: 1'b0};
    vecs[5] = '{op: 2'd2, a: 32'd7,        b: 32'hFFFFFFFE, hi: 32'h00000001, lo: 32'hFFFFFFFD, dz: 1'b0};
    vecs[6] = '{op: 2'd2, a: 32'hFFFFFFF9, b: 32'd0,        hi: 32'hFFFFFFF9, lo: 32'hFFFFFFFF, dz: 1'b1};

    bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_dz", 64'(bus.div_by_zero), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    exp_hi = '0;
    exp_lo = '0;

    // Table vectors run back-to-back: each start is raised in the previous done cycle.
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      finish_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tbl_hi", i), 64'(bus.hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_tbl_lo", i), 64'(bus.lo), 64'(vecs[i].lo));
      chk($sformatf("vec%0d_tbl_dz", i), 64'(bus.div_by_zero), 64'(vecs[i].dz));
    end

    // DIVU by zero: flag only in the done cycle
    @(negedge clk);
    run_op(2'd3, 32'd5, 32'd0, "divu_by0");
    chk("divu_by0_lo_const", 64'(bus.lo), 64'hFFFFFFFF);
    chk("divu_by0_hi_const", 64'(bus.hi), 64'd5);
    @(posedge clk); #1;
    chk("divu_by0_dz_after", 64'(bus.div_by_zero), 64'd0);
    chk("divu_by0_done_after", 64'(bus.done), 64'd0);

    // MTHI in IDLE
    @(negedge clk);
    bus.wr_hi = 1'b1; bus.wr_data = 32'h1234;
    @(posedge clk); #1;
    bus.wr_hi = 1'b0;
    chk("mthi_hi", 64'(bus.hi), 64'h1234);
    chk("mthi_lo_kept", 64'(bus.lo), 64'(exp_lo));
    exp_hi = 32'h1234;

    // MTHI and MTLO together
    @(negedge clk);
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'hA5A5_0F0F;
    @(posedge clk); #1;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    chk("mthilo_both", {bus.hi, bus.lo}, {32'hA5A5_0F0F, 32'hA5A5_0F0F});
    exp_hi = 32'hA5A5_0F0F;
    exp_lo = 32'hA5A5_0F0F;

    // MTLO held during busy must not land
    @(negedge clk);
    issue(2'd1, 32'd1000, 32'd3);
    bus.wr_lo = 1'b1; bus.wr_data = 32'hBEEF;
    finish_op(2'd1, 32'd1000, 32'd3, "wrlo_busy");
    bus.wr_lo = 1'b0;

    // start wins over MTHI on the same edge
    @(negedge clk);
    bus.wr_hi = 1'b1; bus.wr_data = 32'hDEAD;
    issue(2'd3, 32'd100, 32'd7);
    bus.wr_hi = 1'b0;
    chk("start_wins_hi", 64'(bus.hi), 64'(exp_hi));
    finish_op(2'd3, 32'd100, 32'd7, "start_wins");

    // random operations, some back-to-back
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? '0 : 32'($urandom);
      if ($urandom_range(0, 9) == 0) begin ra = 32'h80000000; rb = '1; end
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      run_op(rop, ra, rb, $sformatf("rnd%0d", i));
    end

    // reset in the middle of a DIVU
    @(negedge clk);
    issue(2'd3, 32'd12345, 32'd17);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("midrst_no_done", 64'(bus.done), 64'd0);
    end
    @(negedge clk) rst = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    run_op(2'd1, 32'd3, 32'd4, "post_rst_multu");
    chk("post_rst_lo12", {bus.hi, bus.lo}, 64'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand width and the width of each of HI and LO.
REQ-002 The module SHALL have an input clk, 1 bit, the single clock; all state SHALL change on the rising edge.
REQ-003 The module SHALL have an input rst, 1 bit; reset is asynchronous and active-high.
REQ-004 The module SHALL have an input start, 1 bit, requesting a new operation.
REQ-005 The module SHALL have an input op, 2 bits, encoded 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The module SHALL have inputs a and b, WIDTH bits each, where a is the multiplicand or dividend and b is the multiplier or divisor.
REQ-007 The module SHALL have inputs wr_hi and wr_lo, 1 bit each, as the MTHI and MTLO write enables.
REQ-008 The module SHALL have an input wr_data, WIDTH bits, the data for an MTHI or MTLO write.
REQ-009 The module SHALL have an output busy, 1 bit, high while an operation is in progress.
REQ-010 The module SHALL have an output done, 1 bit, a one-cycle pulse marking that a result has been written.
REQ-011 The module SHALL have an output div_by_zero, 1 bit, qualified by done.
REQ-012 The module SHALL have outputs hi and lo, WIDTH bits each, driven directly from registers.

Function
REQ-013 The module SHALL implement three states:
- IDLE, where busy is 0.
- RUN, where busy is 1.
- FINISH, where busy is 1.
REQ-014 In IDLE, when start=1 on an edge (call it E0), the module SHALL:
- latch op, a and b;
- form the operand magnitudes, using two's-complement absolute value only for the signed ops (MULT, DIV);
- clear the iteration counter;
- move to RUN.
REQ-015 The module SHALL ignore start while busy=1; no queueing and no error indication.
REQ-016 In RUN, the module SHALL perform exactly one iteration per edge:
- MULT/MULTU: one shift-add step on a 2*WIDTH-bit product register.
- DIV/DIVU: one restoring shift-subtract step on WIDTH-bit quotient and remainder registers.
REQ-017 On the WIDTH-th iteration edge (E0+WIDTH), the module SHALL move from RUN to FINISH.
REQ-018 On edge E0+WIDTH+1, the module SHALL:
- apply sign correction;
- write hi and lo;
- set done=1 for exactly one cycle;
- return to IDLE.
Total latency is WIDTH+1 edges after E0, and busy SHALL be low in the cycle in which done is high.
REQ-019 When done=1 and start=1 on the same edge, the module SHALL accept the new operation (back-to-back, no bubble).
REQ-020 Multiply results SHALL be placed as {hi,lo} = the full 2*WIDTH-bit product. For MULT, the product SHALL be negated when the operand signs differ.
REQ-021 Divide results SHALL be placed as lo = quotient and hi = remainder, with these sign rules for DIV:
- the quotient is negated when the operand signs differ;
- the remainder takes the sign of a.
REQ-022 DIV of the most-negative value by -1 SHALL yield lo = most-negative value and hi = 0, with no flag.
REQ-023 For divide with b=0, the module SHALL:
- take the full latency;
- set lo = all ones and hi = the latched a;
- set div_by_zero=1 during the done cycle.
div_by_zero SHALL be 0 at all other times, and for all multiplies.
REQ-024 wr_hi and wr_lo SHALL take effect only in IDLE with start=0. On such an edge, hi and/or lo SHALL load wr_data; both may be set together.
REQ-025 wr_hi and wr_lo SHALL be ignored while busy=1, and also when start=1 on the same edge (start wins).
REQ-026 hi and lo SHALL change only under REQ-018 or REQ-024, and SHALL hold their values during RUN and FINISH.

Reset
REQ-027 While rst=1, the module SHALL immediately force: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, iteration counter=0, all datapath registers 0.
REQ-028 rst asserted mid-operation SHALL abort the operation with no done pulse. The first edge after rst deasserts SHALL accept start.

Verification
REQ-029 The bench SHALL cover the following scenarios with WIDTH=32:
- MULT: a=0xFFFFFFFD, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done exactly 33 edges after the start edge; busy=1 throughout the preceding 32 cycles.
- MULTU: a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then start MULT in the done cycle -> accepted, busy=1 in the next cycle.
- DIV: a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- DIVU: a=5, b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 only in the done cycle.
- MTHI with wr_data=0x1234 in IDLE -> hi=0x1234, lo unchanged; wr_lo during busy -> lo unchanged; start and wr_hi on the same edge -> operation starts, hi unchanged until done.
- rst pulsed at iteration 10 of a DIVU -> busy, hi and lo are 0 with no done pulse; a new MULTU 3*4 then yields hi=0, lo=12.
